// File: rtl/rvskidbuf_w32_if.sv
// Valid/ready bundle for the 32-bit skid buffer: producer side, consumer side and flush.
interface rvskidbuf_w32_if #(
   parameter int unsigned WIDTH = 32
);
   localparam int unsigned OCC_W = 2;

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [OCC_W-1:0] occupancy;

   // Environment side: drives producer/consumer controls, observes the buffer
   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, occupancy
   );

   // Buffer side
   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, occupancy
   );
endinterface

// File: rtl/rvskidbuf_w32.sv
// Two-entry valid/ready skid buffer. in_ready and out_valid come straight
// from flops so neither handshake input reaches them combinationally.
module rvskidbuf_w32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_l,
   rvskidbuf_w32_if.slave bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             accept, pop;

   assign accept = bus.in_valid & in_ready_q;
   assign pop    = out_valid_q & bus.out_ready;

   // Next-state and data-capture decisions; flush overrides every transition
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               main_d  = bus.in_data;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && pop) begin
               main_d = bus.in_data;
            end else if (accept) begin
               skid_d  = bus.in_data;
               state_d = TWO;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (bus.flush) begin
         state_d = EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end
      in_ready_d  = (state_d != TWO);
      out_valid_d = (state_d != EMPTY);
   end

   // State, payload and handshake flops
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q     <= EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = main_q;
   assign bus.occupancy = state_q;

endmodule

// File: tb/tb_rvskidbuf_w32.sv
// Bench for rvskidbuf_w32: directed scenarios plus random traffic, all checked
// by a queue-based scoreboard sampled away from the active edge.
module tb_rvskidbuf_w32;
   localparam int unsigned WIDTH = 32;

   logic clk = 1'b0;
   logic rst_l;

   rvskidbuf_w32_if #(.WIDTH(WIDTH)) bif ();

   rvskidbuf_w32 #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_l (rst_l),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   int checks  = 0;
   int errors  = 0;
   int pop_cnt = 0;
   bit mon_en  = 1'b0;
   logic [WIDTH-1:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_out_valid"}, 32'(bif.out_valid), 32'd0);
      chk({tag, "_in_ready"},  32'(bif.in_ready),  32'd1);
      chk({tag, "_occupancy"}, 32'(bif.occupancy), 32'd0);
      chk({tag, "_out_data"},  bif.out_data,       32'd0);
   endtask

   // One cycle of stimulus, driven on the falling edge
   task automatic cyc(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
      @(negedge clk);
      bif.in_valid  = iv;
      bif.in_data   = d;
      bif.out_ready = ordy;
      bif.flush     = fl;
   endtask

   // Producer holds the payload until the buffer takes it
   task automatic send(input logic [WIDTH-1:0] d, input logic ordy);
      int k;
      k = 0;
      do begin
         cyc(1'b1, d, ordy, 1'b0);
         k++;
      end while (!bif.in_ready && k < 20);
      if (!bif.in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready=0 expected 1 within 20 cycles");
      end
   endtask

   // Scoreboard monitor: expected contents are the ordered list of accepted,
   // not-yet-popped, not-flushed payloads
   initial begin : monitor
      logic             prev_hold;
      logic [WIDTH-1:0] prev_data;
      int               n;
      prev_hold = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_l) begin
            exp_q.delete();
            prev_hold = 1'b0;
         end else if (mon_en) begin
            n = exp_q.size();
            chk("occupancy", 32'(bif.occupancy), 32'(n));
            chk("out_valid", 32'(bif.out_valid), 32'(n > 0));
            chk("in_ready",  32'(bif.in_ready),  32'(n < 2));
            if (n > 0) chk("out_data", bif.out_data, exp_q[0]);
            if (prev_hold) chk("hold_stable", bif.out_data, prev_data);
            if (bif.out_valid && bif.out_ready && n > 0) begin
               void'(exp_q.pop_front());
               pop_cnt++;
            end
            if (bif.in_valid && bif.in_ready && !bif.flush) exp_q.push_back(bif.in_data);
            if (bif.flush) exp_q.delete();
            prev_hold = bif.out_valid && !bif.out_ready && !bif.flush;
            prev_data = bif.out_data;
         end
      end
   end

   initial begin : stimulus
      int               base;
      logic             hold;
      logic [WIDTH-1:0] hold_d;
      logic             iv, ordy, fl;
      logic [WIDTH-1:0] d;
      int               rdy_pct;

      rst_l         = 1'b1;
      bif.flush     = 1'b0;
      bif.in_valid  = 1'b0;
      bif.in_data   = '0;
      bif.out_ready = 1'b0;

      // Asynchronous reset between edges
      #2 rst_l = 1'b0;
      #1 reset_check("rst_async");
      repeat (2) @(negedge clk);
      #3 reset_check("rst_hold");
      rst_l  = 1'b1;
      mon_en = 1'b1;

      // Full-rate streaming
      base = pop_cnt;
      for (int i = 1; i <= 8; i++) cyc(1'b1, 32'(i), 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      #2 chk("stream_pops", 32'(pop_cnt - base), 32'd8);

      // Stall fills both entries, third payload held back
      base = pop_cnt;
      send(32'hAAAA0001, 1'b0);
      send(32'hAAAA0002, 1'b0);
      cyc(1'b1, 32'hAAAA0003, 1'b0, 1'b0);
      #2;
      chk("stall_occupancy", 32'(bif.occupancy), 32'd2);
      chk("stall_in_ready",  32'(bif.in_ready),  32'd0);
      send(32'hAAAA0003, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      #2 chk("stall_pops", 32'(pop_cnt - base), 32'd3);

      // Flush from TWO coinciding with a pop
      base = pop_cnt;
      send(32'h11111111, 1'b0);
      send(32'h22222222, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      #2;
      chk("flush2_occupancy", 32'(bif.occupancy), 32'd0);
      chk("flush2_out_valid", 32'(bif.out_valid), 32'd0);
      chk("flush2_in_ready",  32'(bif.in_ready),  32'd1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      #2 chk("flush2_pops", 32'(pop_cnt - base), 32'd1);

      // Flush in ONE coinciding with an accept
      send(32'h33333333, 1'b0);
      cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
      #2 chk("flush1_handshake", 32'(bif.in_ready), 32'd1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      #2;
      chk("flush1_occupancy", 32'(bif.occupancy), 32'd0);
      chk("flush1_out_valid", 32'(bif.out_valid), 32'd0);
      cyc(1'b0, '0, 1'b1, 1'b0);

      // Reset while two entries are held
      send(32'h00000101, 1'b0);
      send(32'h00000202, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      #3 rst_l = 1'b0;
      #1 reset_check("rst_mid");
      @(negedge clk);
      #3 rst_l = 1'b1;
      cyc(1'b0, '0, 1'b1, 1'b0);

      // Random traffic, producer holds unaccepted payloads
      hold    = 1'b0;
      hold_d  = '0;
      rdy_pct = 50;
      for (int c = 0; c < 10000; c++) begin
         if (c % 500 == 0) rdy_pct = int'($urandom_range(10, 95));
         iv   = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
         d    = hold ? hold_d : WIDTH'($urandom);
         ordy = (int'($urandom_range(0, 99)) < rdy_pct);
         fl   = ($urandom_range(0, 63) == 0);
         cyc(iv, d, ordy, fl);
         hold   = iv && !bif.in_ready;
         hold_d = d;
      end

      repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
      #2 chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
